// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, optional odd/even parity,
// one or two stop bits, input synchroniser, start-glitch rejection and error flags.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 r_State;
    logic                   r_Sync1;
    logic                   r_Sync2;
    logic [CNT_W-1:0]       r_Clk_Cnt;
    logic [IDX_W-1:0]       r_Bit_Idx;
    logic [DATA_BITS-1:0]   r_Data;
    logic                   r_Par_Err;
    logic                   r_Stop_Low;
    logic                   r_RX_DV;
    logic [DATA_BITS-1:0]   r_RX_Byte;
    logic                   r_Parity_Err;
    logic                   r_Frame_Err;
    logic                   w_Stop_Err;
    logic                   w_Data_Xor;

    // Idle-high reset value keeps a freshly reset receiver from seeing a false start.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Sync1 <= 1'b1;
            r_Sync2 <= 1'b1;
        end else begin
            r_Sync1 <= i_RX_Serial;
            r_Sync2 <= r_Sync1;
        end
    end

    assign w_Stop_Err = r_Stop_Low | ~r_Sync2;
    assign w_Data_Xor = ^{r_Data, r_Sync2};

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State      <= S_IDLE;
            r_Clk_Cnt    <= '0;
            r_Bit_Idx    <= '0;
            r_Data       <= '0;
            r_Par_Err    <= 1'b0;
            r_Stop_Low   <= 1'b0;
            r_RX_DV      <= 1'b0;
            r_RX_Byte    <= '0;
            r_Parity_Err <= 1'b0;
            r_Frame_Err  <= 1'b0;
        end else begin
            r_RX_DV <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    r_Clk_Cnt <= '0;
                    r_Bit_Idx <= '0;
                    if (!r_Sync2) begin
                        r_State <= S_START;
                    end
                end

                // A start bit that is high again at mid-bit is treated as noise.
                S_START: begin
                    if (r_Clk_Cnt == HALF_BIT) begin
                        r_Clk_Cnt <= '0;
                        r_Bit_Idx <= '0;
                        if (!r_Sync2) begin
                            r_State    <= S_DATA;
                            r_Par_Err  <= 1'b0;
                            r_Stop_Low <= 1'b0;
                        end else begin
                            r_State <= S_IDLE;
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end

                // LSB arrives first, so shifting in from the top leaves it at bit 0.
                S_DATA: begin
                    if (r_Clk_Cnt == LAST_CLK) begin
                        r_Clk_Cnt <= '0;
                        r_Data    <= {r_Sync2, r_Data[DATA_BITS-1:1]};
                        if (r_Bit_Idx == LAST_BIT) begin
                            r_Bit_Idx <= '0;
                            r_State   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_Bit_Idx <= r_Bit_Idx + 1'b1;
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (r_Clk_Cnt == LAST_CLK) begin
                        r_Clk_Cnt <= '0;
                        r_Par_Err <= (PARITY == 1) ? ~w_Data_Xor : w_Data_Xor;
                        r_State   <= S_STOP;
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_Clk_Cnt == LAST_CLK) begin
                        r_Clk_Cnt <= '0;
                        if (r_Bit_Idx == LAST_STOP) begin
                            r_Bit_Idx    <= '0;
                            r_RX_DV      <= 1'b1;
                            r_RX_Byte    <= r_Data;
                            r_Parity_Err <= r_Par_Err;
                            r_Frame_Err  <= w_Stop_Err;
                            r_State      <= w_Stop_Err ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            r_Bit_Idx  <= r_Bit_Idx + 1'b1;
                            r_Stop_Low <= w_Stop_Err;
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end

                // A line held low (break) must not be mistaken for a new start bit.
                S_WAIT_HIGH: begin
                    r_Clk_Cnt <= '0;
                    if (r_Sync2) begin
                        r_State <= S_IDLE;
                    end
                end

                default: begin
                    r_State <= S_IDLE;
                end
            endcase
        end
    end

    assign o_RX_DV      = r_RX_DV;
    assign o_RX_Byte    = r_RX_Byte;
    assign o_Parity_Err = r_Parity_Err;
    assign o_Frame_Err  = r_Frame_Err;
    assign o_Busy       = (r_State != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 at 217 clocks/bit, 8E1 and 7O2 at 16 clocks/bit.
module tb_uart_rx_param;

    logic r_Clock = 1'b0;
    logic r_Reset = 1'b1;
    logic r_Line0 = 1'b1;
    logic r_Line1 = 1'b1;
    logic r_Line2 = 1'b1;

    logic       w_DV0, w_PE0, w_FE0, w_Busy0;
    logic [7:0] w_Byte0;
    logic       w_DV1, w_PE1, w_FE1, w_Busy1;
    logic [7:0] w_Byte1;
    logic       w_DV2, w_PE2, w_FE2, w_Busy2;
    logic [6:0] w_Byte2;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;
    int busy_cycles0 = 0;
    int dv_cnt   [3] = '{0, 0, 0};
    int dv_cycle [3] = '{0, 0, 0};
    logic [8:0] byte_log [3][32];
    logic       pe_log   [3][32];
    logic       fe_log   [3][32];

    always #5 r_Clock = ~r_Clock;

    uart_rx_param dut0 (
        .i_Clock(r_Clock), .i_Reset(r_Reset), .i_RX_Serial(r_Line0),
        .o_RX_DV(w_DV0), .o_RX_Byte(w_Byte0), .o_Parity_Err(w_PE0),
        .o_Frame_Err(w_FE0), .o_Busy(w_Busy0)
    );

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .i_Clock(r_Clock), .i_Reset(r_Reset), .i_RX_Serial(r_Line1),
        .o_RX_DV(w_DV1), .o_RX_Byte(w_Byte1), .o_Parity_Err(w_PE1),
        .o_Frame_Err(w_FE1), .o_Busy(w_Busy1)
    );

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
        .i_Clock(r_Clock), .i_Reset(r_Reset), .i_RX_Serial(r_Line2),
        .o_RX_DV(w_DV2), .o_RX_Byte(w_Byte2), .o_Parity_Err(w_PE2),
        .o_Frame_Err(w_FE2), .o_Busy(w_Busy2)
    );

    always @(posedge r_Clock) cycle_cnt <= cycle_cnt + 1;

    // Log every DV pulse so back-to-back frames can be checked afterwards.
    always @(negedge r_Clock) begin
        if (w_Busy0) busy_cycles0 <= busy_cycles0 + 1;
        if (w_DV0) begin
            byte_log[0][dv_cnt[0] % 32] <= {1'b0, w_Byte0};
            pe_log[0][dv_cnt[0] % 32]   <= w_PE0;
            fe_log[0][dv_cnt[0] % 32]   <= w_FE0;
            dv_cycle[0]                 <= cycle_cnt;
            dv_cnt[0]                   <= dv_cnt[0] + 1;
        end
        if (w_DV1) begin
            byte_log[1][dv_cnt[1] % 32] <= {1'b0, w_Byte1};
            pe_log[1][dv_cnt[1] % 32]   <= w_PE1;
            fe_log[1][dv_cnt[1] % 32]   <= w_FE1;
            dv_cycle[1]                 <= cycle_cnt;
            dv_cnt[1]                   <= dv_cnt[1] + 1;
        end
        if (w_DV2) begin
            byte_log[2][dv_cnt[2] % 32] <= {2'b0, w_Byte2};
            pe_log[2][dv_cnt[2] % 32]   <= w_PE2;
            fe_log[2][dv_cnt[2] % 32]   <= w_FE2;
            dv_cycle[2]                 <= cycle_cnt;
            dv_cnt[2]                   <= dv_cnt[2] + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic driveLine(input int sel, input logic value);
        case (sel)
            0:       r_Line0 = value;
            1:       r_Line1 = value;
            default: r_Line2 = value;
        endcase
    endtask

    function automatic logic [15:0] buildFrame(input logic [8:0] data, input int n_data,
                                               input int has_par, input logic par_bit,
                                               input logic stop_a, input logic stop_b,
                                               input int n_stop);
        logic [15:0] f;
        int p;
        f = '1;
        f[0] = 1'b0;
        p = 1;
        for (int i = 0; i < n_data; i++) begin
            f[p] = data[i];
            p++;
        end
        if (has_par != 0) begin
            f[p] = par_bit;
            p++;
        end
        f[p] = stop_a;
        p++;
        if (n_stop == 2) f[p] = stop_b;
        return f;
    endfunction

    // Bit i is driven just after edge start+i*cpb; the line keeps the last bit on return.
    task automatic applyStimulus(input int sel, input logic [15:0] bits, input int n_bits,
                                 input int cpb, output int start_cycle);
        start_cycle = 0;
        for (int i = 0; i < n_bits; i++) begin
            @(posedge r_Clock);
            #1;
            driveLine(sel, bits[i]);
            if (i == 0) start_cycle = cycle_cnt;
            repeat (cpb - 1) @(posedge r_Clock);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge r_Clock);
        #1;
    endtask

    initial begin
        int t0;
        int b0;

        idle(3);
        checkOutput("rst_dv",    w_DV0,   0);
        checkOutput("rst_byte",  w_Byte0, 0);
        checkOutput("rst_pe",    w_PE0,   0);
        checkOutput("rst_fe",    w_FE0,   0);
        checkOutput("rst_busy",  w_Busy0, 0);
        checkOutput("rst_byte2", w_Byte2, 0);
        r_Reset = 1'b0;
        idle(5);

        // 8N1 at 217: latency from line fall = 3 (sync + IDLE) + 109 + 9*217 = 2065
        $display("[TB] 8N1 frame 0x37");
        b0 = busy_cycles0;
        applyStimulus(0, buildFrame(9'h037, 8, 0, 1'b0, 1'b1, 1'b1, 1), 10, 217, t0);
        idle(20);
        checkOutput("t1_dv_cnt",  dv_cnt[0], 1);
        checkOutput("t1_byte",    byte_log[0][0], 9'h037);
        checkOutput("t1_pe",      pe_log[0][0], 0);
        checkOutput("t1_fe",      fe_log[0][0], 0);
        checkOutput("t1_latency", dv_cycle[0] - t0, 2065);
        checkOutput("t1_busy_len", busy_cycles0 - b0, 2062);
        checkOutput("t1_busy_end", w_Busy0, 0);

        // 8E1 at 16: latency = 3 + 8 + 10*16 = 171
        $display("[TB] 8E1 frames 0xA5");
        applyStimulus(1, buildFrame(9'h0A5, 8, 1, 1'b0, 1'b1, 1'b1, 1), 11, 16, t0);
        idle(10);
        checkOutput("t2a_dv_cnt",  dv_cnt[1], 1);
        checkOutput("t2a_byte",    byte_log[1][0], 9'h0A5);
        checkOutput("t2a_pe",      pe_log[1][0], 0);
        checkOutput("t2a_fe",      fe_log[1][0], 0);
        checkOutput("t2a_latency", dv_cycle[1] - t0, 171);
        applyStimulus(1, buildFrame(9'h0A5, 8, 1, 1'b1, 1'b1, 1'b1, 1), 11, 16, t0);
        idle(10);
        checkOutput("t2b_dv_cnt", dv_cnt[1], 2);
        checkOutput("t2b_byte",   byte_log[1][1], 9'h0A5);
        checkOutput("t2b_pe",     pe_log[1][1], 1);
        checkOutput("t2b_hold_pe", w_PE1, 1);

        $display("[TB] start glitch");
        idle(1);
        r_Line0 = 1'b0;
        idle(50);
        checkOutput("t3_busy_glitch", w_Busy0, 1);
        r_Line0 = 1'b1;
        idle(111);
        checkOutput("t3_busy_back", w_Busy0, 0);
        idle(5000);
        checkOutput("t3_no_dv", dv_cnt[0], 1);

        $display("[TB] framing error and break");
        applyStimulus(0, buildFrame(9'h055, 8, 0, 1'b0, 1'b0, 1'b1, 1), 10, 217, t0);
        idle(3000);
        checkOutput("t4_dv_cnt",  dv_cnt[0], 2);
        checkOutput("t4_byte",    byte_log[0][1], 9'h055);
        checkOutput("t4_fe",      fe_log[0][1], 1);
        checkOutput("t4_pe",      pe_log[0][1], 0);
        checkOutput("t4_busy_wait", w_Busy0, 1);
        r_Line0 = 1'b1;
        idle(10);
        checkOutput("t4_busy_rel", w_Busy0, 0);
        applyStimulus(0, buildFrame(9'h012, 8, 0, 1'b0, 1'b1, 1'b1, 1), 10, 217, t0);
        idle(20);
        checkOutput("t4b_dv_cnt", dv_cnt[0], 3);
        checkOutput("t4b_byte",   byte_log[0][2], 9'h012);
        checkOutput("t4b_fe",     fe_log[0][2], 0);

        // 7O2: 0x41 has two ones, so the odd parity bit is 1
        $display("[TB] 7O2 frames 0x41");
        applyStimulus(2, buildFrame(9'h041, 7, 1, 1'b1, 1'b1, 1'b1, 2), 11, 16, t0);
        idle(10);
        checkOutput("t5a_dv_cnt",  dv_cnt[2], 1);
        checkOutput("t5a_byte",    byte_log[2][0], 9'h041);
        checkOutput("t5a_pe",      pe_log[2][0], 0);
        checkOutput("t5a_fe",      fe_log[2][0], 0);
        checkOutput("t5a_latency", dv_cycle[2] - t0, 171);
        applyStimulus(2, buildFrame(9'h041, 7, 1, 1'b1, 1'b1, 1'b0, 2), 11, 16, t0);
        r_Line2 = 1'b1;
        idle(10);
        checkOutput("t5b_dv_cnt", dv_cnt[2], 2);
        checkOutput("t5b_byte",   byte_log[2][1], 9'h041);
        checkOutput("t5b_pe",     pe_log[2][1], 0);
        checkOutput("t5b_fe",     fe_log[2][1], 1);
        checkOutput("t5b_busy",   w_Busy2, 0);

        // Data bit 4 of 0xFF spans 1085..1301 cycles after the start edge
        $display("[TB] reset mid-frame then back-to-back");
        idle(1);
        r_Line0 = 1'b0;
        idle(217);
        r_Line0 = 1'b1;
        idle(976);
        checkOutput("t6_busy_pre", w_Busy0, 1);
        r_Reset = 1'b1;
        idle(1);
        r_Reset = 1'b0;
        checkOutput("t6_rst_byte", w_Byte0, 0);
        checkOutput("t6_rst_busy", w_Busy0, 0);
        idle(2000);
        checkOutput("t6_no_dv", dv_cnt[0], 3);
        applyStimulus(0, buildFrame(9'h03C, 8, 0, 1'b0, 1'b1, 1'b1, 1), 10, 217, t0);
        idle(20);
        checkOutput("t6_dv_cnt", dv_cnt[0], 4);
        checkOutput("t6_byte",   byte_log[0][3], 9'h03C);
        applyStimulus(0, buildFrame(9'h001, 8, 0, 1'b0, 1'b1, 1'b1, 1), 10, 217, t0);
        applyStimulus(0, buildFrame(9'h080, 8, 0, 1'b0, 1'b1, 1'b1, 1), 10, 217, t0);
        idle(20);
        checkOutput("t6_b2b_cnt",  dv_cnt[0], 6);
        checkOutput("t6_b2b_byte0", byte_log[0][4], 9'h001);
        checkOutput("t6_b2b_byte1", byte_log[0][5], 9'h080);
        checkOutput("t6_b2b_fe",   fe_log[0][5], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver. Supports a configurable data width, optional odd/even parity, and one or two stop bits. Adds an input synchroniser, start-bit glitch rejection, parity/framing error flags and a busy indicator. Sits between the board RX pin and byte-consuming logic (command decoder, FIFO).

Parameters:
CLKS_PER_BIT, 217, clocks per bit (25 MHz / 115200); legal range >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits expected; 1 or 2.

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Reset  in  1  synchronous, active-high reset
i_RX_Serial  in  1  asynchronous serial line; idles high
o_RX_DV  out  1  one-cycle pulse when a frame completes
o_RX_Byte  out  DATA_BITS  received data, LSB = first bit on the wire
o_Parity_Err  out  1  parity mismatch for the last frame; valid with o_RX_DV
o_Frame_Err  out  1  a stop bit was sampled low; valid with o_RX_DV
o_Busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (i_Reset high at a clock edge):
  - state IDLE; all counters 0.
  - Both synchroniser flops set to 1.
  - o_RX_DV, o_Parity_Err, o_Frame_Err, o_Busy = 0; o_RX_Byte = 0.
  - Reset mid-frame abandons the frame with no DV.
- Input path: two-flop synchroniser; the FSM only sees r_Sync2. Latency is 2 clocks.
- Half-bit constant H = (CLKS_PER_BIT-1)/2, integer division.
- Bit counter r_Clk_Cnt: width $clog2(CLKS_PER_BIT). Bit index r_Bit_Idx: width $clog2(DATA_BITS)+1.
- States:
  - IDLE: r_Sync2==0 -> START, r_Clk_Cnt=0.
  - START: if r_Clk_Cnt==H, re-sample r_Sync2.
    - Low -> DATA, r_Clk_Cnt=0, r_Bit_Idx=0.
    - High -> IDLE (glitch, no DV, no flags).
    - Otherwise r_Clk_Cnt++.
  - DATA: at r_Clk_Cnt==CLKS_PER_BIT-1, store r_Sync2 into bit r_Bit_Idx, clear the counter, increment the index.
    - After bit DATA_BITS-1: go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample at CLKS_PER_BIT-1.
    - Even mode: error if XOR(data, parity bit) is 1.
    - Odd mode: error if that XOR is 0.
  - STOP: sample each of the STOP_BITS at CLKS_PER_BIT-1. Any low sample latches a frame error.
    - On the edge of the last stop sample, drive o_RX_DV=1 for exactly one cycle. Load o_RX_Byte, o_Parity_Err and o_Frame_Err on that same edge.
    - Then go to IDLE if there is no frame error, else WAIT_HIGH.
  - WAIT_HIGH (break/framing recovery): stay until r_Sync2==1, then IDLE. This prevents a held-low line from re-triggering.
- Outputs o_RX_Byte and the error flags hold until the next DV; they are not cleared by the DV falling.
- Timing: E0 is the edge at which IDLE first sees r_Sync2==0, and N = DATA_BITS + (PARITY!=0) + STOP_BITS.
  - Sample k (k=1..N) occurs at E0 + H + 1 + k*CLKS_PER_BIT.
  - o_RX_DV is high in the cycle following sample N.
  - For 8N1 at 217: DV rises at E0+2062.
- Back-to-back frames: a start edge directly after the last stop sample is accepted. The IDLE state is occupied for at least one cycle, and CLKS_PER_BIT-1-H cycles of stop-bit margin remain.
- No receive buffering: an unconsumed o_RX_Byte is overwritten by the next frame.

Test Plan:
1. Defaults (8N1, 217): send 0x37 with a 217-clock bit period -> one DV pulse at E0+2062, o_RX_Byte=0x37, both error flags 0; o_Busy high from E0 until DV.
2. PARITY=2, DATA_BITS=8:
   - Send 0xA5 with parity bit 0 -> DV, byte 0xA5, o_Parity_Err=0.
   - Repeat with parity bit 1 -> o_Parity_Err=1, byte still 0xA5.
3. Drive the line low for 50 clocks, then high -> no DV for 5000 cycles; o_Busy returns to 0 within H+3 cycles.
4. Send 0x55 with the stop bit low and hold the line low for 3000 clocks -> DV with o_Frame_Err=1; no second DV while low. Then release high and send 0x12 -> DV, byte 0x12, o_Frame_Err=0.
5. DATA_BITS=7, PARITY=1, STOP_BITS=2: send 0x41 with correct odd parity -> byte 0x41, no errors. Send again with the second stop bit low -> o_Frame_Err=1.
6. Assert i_Reset for 1 cycle mid-way through data bit 4 of 0xFF, then send 0x3C cleanly -> no DV for the aborted frame, then DV with byte 0x3C. Follow with back-to-back 0x01, 0x80 with no idle gap -> two DVs, bytes correct.
